// File: rtl/countdown_timer8.sv
// rtl/countdown_timer8.sv - prescaled 8-bit down-counting timer with one-shot and auto-reload modes
module countdown_timer8 #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             reload_mode,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done_pulse
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] reload_val;
    logic [PW-1:0]    presc;
    logic             tick;
    logic             at_one;
    logic             at_zero;
    logic             tick_done;

    assign tick    = (state == S_RUN) && (presc == LAST);
    assign at_one  = (count == WIDTH'(1));
    assign at_zero = (count == '0);
    // A zero reached in RUN ends the run unless there is a nonzero value to reload.
    assign tick_done = tick && ((at_one && !reload_mode) ||
                                (at_zero && (!reload_mode || reload_val == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            reload_val <= '0;
            presc      <= '0;
            state      <= S_IDLE;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (clear) begin
                count <= '0;
                presc <= '0;
                state <= S_IDLE;
            end else if (load) begin
                count      <= load_val;
                reload_val <= load_val;
                presc      <= '0;
                state      <= S_IDLE;
            end else if (start && ((state == S_IDLE && !at_zero) || state == S_PAUSE)) begin
                state <= S_RUN;
                if (state == S_IDLE) begin
                    presc <= '0;
                end
            end else if (state == S_RUN) begin
                if (tick) begin
                    presc <= '0;
                    if (at_zero) begin
                        if (!tick_done) begin
                            count <= reload_val;
                        end
                    end else begin
                        count <= count - 1'b1;
                        if (at_one) begin
                            done_pulse <= 1'b1;
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
                // The edge that samples pause still completes its RUN cycle, then freezes.
                if (tick_done) begin
                    state <= S_DONE;
                end else if (pause) begin
                    state <= S_PAUSE;
                end
            end
        end
    end

    assign running = (state == S_RUN);
    assign expired = (state == S_DONE);

endmodule

// File: tb/tb_countdown_timer8.sv
// tb/tb_countdown_timer8.sv - directed self-checking bench for countdown_timer8 (PRESCALE=4)
module tb_countdown_timer8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic       clear;
    logic       reload_mode;
    logic [7:0] count;
    logic       running;
    logic       expired;
    logic       done_pulse;

    int tests = 0;
    int fails = 0;

    countdown_timer8 #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .clear(clear), .reload_mode(reload_mode),
        .count(count), .running(running), .expired(expired), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v; load = 1'b1;
        tick_n(1);
        load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick_n(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; load_val = 8'd0; start = 1'b0;
        pause = 1'b0; clear = 1'b0; reload_mode = 1'b0;
        #3;
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b expected 0", running); end
        tests++; if (expired !== 1'b0) begin fails++; $display("FAIL reset_expired: got %b expected 0", expired); end
        tests++; if (done_pulse !== 1'b0) begin fails++; $display("FAIL reset_done_pulse: got %b expected 0", done_pulse); end
        #4 rst_n = 1'b1;
        tick_n(2);
        tests++; if (count !== 8'd0 || running !== 1'b0) begin fails++; $display("FAIL reset_release: got count=%0d running=%b expected 0/0", count, running); end
    endtask

    task automatic test_one_shot();
        int exp_c;
        do_load(8'd3);
        tests++; if (count !== 8'd3 || running !== 1'b0) begin fails++; $display("FAIL os_load: got count=%0d running=%b expected 3/0", count, running); end
        reload_mode = 1'b0; start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tests++; if (count !== 8'd3 || running !== 1'b1) begin fails++; $display("FAIL os_start: got count=%0d running=%b expected 3/1", count, running); end
        for (int e = 1; e <= 12; e++) begin
            tick_n(1);
            exp_c = 3 - e / 4;
            tests++; if (count !== exp_c[7:0]) begin fails++; $display("FAIL os_count e=%0d: got %0d expected %0d", e, count, exp_c); end
            tests++; if (done_pulse !== (e == 12)) begin fails++; $display("FAIL os_pulse e=%0d: got %b expected %b", e, done_pulse, (e == 12)); end
        end
        tests++; if (expired !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL os_done_state: got expired=%b running=%b expected 1/0", expired, running); end
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            tests++; if (count !== 8'd0 || done_pulse !== 1'b0 || expired !== 1'b1) begin
                fails++; $display("FAIL os_hold i=%0d: got count=%0d pulse=%b expired=%b expected 0/0/1", i, count, done_pulse, expired);
            end
        end
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tests++; if (expired !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL os_start_in_done: got expired=%b running=%b expected 1/0", expired, running); end
        do_clear();
    endtask

    task automatic test_auto_reload();
        logic [7:0] seq [7];
        int k;
        seq = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
        do_load(8'd2);
        reload_mode = 1'b1; start = 1'b1;
        tick_n(1);
        start = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick_n(1);
            k = e / 4;
            tests++; if (count !== seq[k]) begin fails++; $display("FAIL ar_count e=%0d: got %0d expected %0d", e, count, seq[k]); end
            tests++; if (done_pulse !== ((e % 4 == 0) && seq[k] == 8'd0)) begin
                fails++; $display("FAIL ar_pulse e=%0d: got %b expected %b", e, done_pulse, ((e % 4 == 0) && seq[k] == 8'd0));
            end
            tests++; if (running !== 1'b1) begin fails++; $display("FAIL ar_running e=%0d: got %b expected 1", e, running); end
        end
        do_clear();
        tests++; if (count !== 8'd0 || running !== 1'b0 || expired !== 1'b0) begin
            fails++; $display("FAIL ar_clear: got count=%0d running=%b expired=%b expected 0/0/0", count, running, expired);
        end
        reload_mode = 1'b0;
    endtask

    task automatic test_pause_resume();
        do_load(8'd5);
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tick_n(4);
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL pr_first_tick: got %0d expected 4", count); end
        tick_n(1);
        pause = 1'b1;
        tick_n(1);
        pause = 1'b0;
        tests++; if (running !== 1'b0 || count !== 8'd4) begin fails++; $display("FAIL pr_paused: got running=%b count=%0d expected 0/4", running, count); end
        for (int i = 0; i < 10; i++) begin
            tick_n(1);
            tests++; if (count !== 8'd4 || running !== 1'b0) begin fails++; $display("FAIL pr_hold i=%0d: got count=%0d running=%b expected 4/0", i, count, running); end
        end
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tests++; if (running !== 1'b1 || count !== 8'd4) begin fails++; $display("FAIL pr_resume: got running=%b count=%0d expected 1/4", running, count); end
        tick_n(1);
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL pr_resume_plus1: got %0d expected 4", count); end
        tick_n(1);
        tests++; if (count !== 8'd3) begin fails++; $display("FAIL pr_resume_plus2: got %0d expected 3", count); end
        do_clear();
    endtask

    task automatic test_priority();
        do_load(8'd7);
        clear = 1'b1; load = 1'b1; load_val = 8'd9;
        tick_n(1);
        clear = 1'b0; load = 1'b0;
        tests++; if (count !== 8'd0 || running !== 1'b0 || expired !== 1'b0) begin
            fails++; $display("FAIL prio_clear_load: got count=%0d running=%b expired=%b expected 0/0/0", count, running, expired);
        end
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL prio_start_zero: got running=%b expected 0", running); end
        tick_n(5);
        tests++; if (count !== 8'd0 || running !== 1'b0) begin fails++; $display("FAIL prio_idle_hold: got count=%0d running=%b expected 0/0", count, running); end
    endtask

    task automatic test_async_reset();
        do_load(8'd200);
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tick_n(30);
        tests++; if (count !== 8'd193 || running !== 1'b1) begin fails++; $display("FAIL ar_pre_reset: got count=%0d running=%b expected 193/1", count, running); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (count !== 8'd0 || running !== 1'b0 || expired !== 1'b0) begin
            fails++; $display("FAIL async_reset: got count=%0d running=%b expired=%b expected 0/0/0", count, running, expired);
        end
        #2 rst_n = 1'b1;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        tests++; if (running !== 1'b0 || count !== 8'd0) begin fails++; $display("FAIL async_start_after: got running=%b count=%0d expected 0/0", running, count); end
        tick_n(8);
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL async_idle_hold: got %0d expected 0", count); end
    endtask

    task automatic test_full_range();
        int exp_c;
        int changes;
        logic [7:0] prev;
        reload_mode = 1'b0;
        do_load(8'd255);
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        prev = count;
        changes = 0;
        for (int e = 1; e <= 1020; e++) begin
            tick_n(1);
            exp_c = 255 - e / 4;
            if (count !== prev) changes++;
            prev = count;
            tests++; if (count !== exp_c[7:0]) begin fails++; $display("FAIL fr_count e=%0d: got %0d expected %0d", e, count, exp_c); end
            tests++; if (done_pulse !== (e == 1020)) begin fails++; $display("FAIL fr_pulse e=%0d: got %b expected %b", e, done_pulse, (e == 1020)); end
        end
        tests++; if (changes != 255) begin fails++; $display("FAIL fr_changes: got %0d expected 255", changes); end
        tests++; if (expired !== 1'b1 || running !== 1'b0) begin fails++; $display("FAIL fr_done: got expired=%b running=%b expected 1/0", expired, running); end
        tick_n(4);
        tests++; if (count !== 8'd0 || done_pulse !== 1'b0) begin fails++; $display("FAIL fr_no_underflow: got count=%0d pulse=%b expected 0/0", count, done_pulse); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause_resume();
        test_priority();
        test_async_reset();
        test_full_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
